stage_wb: RTL
=============

Name: stage_wb

Overview:
- Writeback stage and owner of the per-thread architectural register file.
- Writes results from two sources into the register array that the decode stage reads through its `regfile` input:
  - the main pipe (ALU/memory result at the end of the pipeline);
  - the long-latency multiplier pipe.
- When both sources are valid in the same cycle, the multiplier result is buffered in a small in-order FIFO.
- Exports per-register pending bits so hazard detection can stall readers of buffered results.

Parameters:
- N_THREADS, default common::n_threads (4): number of hardware threads / register banks.
- FIFO_DEPTH, default 2: number of buffered multiplier writebacks (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- wb_valid  in  1  main-pipe writeback request.
- wb_thread  in  threadid_t  target thread of the main-pipe write.
- wb_dst  in  regid_t (5)  destination register of the main-pipe write.
- wb_data  in  word_t (32)  main-pipe write data.
- mul_valid  in  1  multiplier writeback request.
- mul_thread  in  threadid_t  target thread of the multiplier write.
- mul_dst  in  regid_t (5)  destination register of the multiplier write.
- mul_data  in  word_t (32)  multiplier write data.
- mul_stall  out  1  FIFO full; the multiplier pipe holds its result and keeps mul_valid asserted.
- pending  out  N_THREADS×32  bit [t][r] set while the FIFO holds a write to register r of thread t.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- regfile  out  word_t[N_THREADS-1:0][31:0]  register file contents, consumed by the decode stage.

Behaviour:
- Reset (rst=0, asynchronous, active-low):
  - all regfile words 0; FIFO empty; fifo_count 0; pending all 0; mul_stall 0.
  - Assertion mid-operation discards buffered writes immediately.
- Register 0 of every thread reads 0 permanently:
  - writes with dst=0 from either source are dropped;
  - a dropped multiplier write is accepted but never enqueued.
- Multiplier acceptance: a multiplier write is accepted iff mul_valid && !mul_stall. mul_stall = (fifo_count == FIFO_DEPTH), derived from registered state.
- Per-cycle priority:
  - wb_valid: the main write is performed at posedge.
  - Else, if the FIFO is non-empty: the head is written and dequeued.
  - An accepted multiplier write enqueues when wb_valid=1 or the FIFO is non-empty (preserves order). Otherwise it is written directly and never enters the FIFO.
  - Enqueue and dequeue in the same cycle are allowed; count is unchanged.
  - When the FIFO is full and the main pipe is idle, the head drains. mul_stall still holds that cycle and drops next cycle.
- Latency: a write is visible on regfile the cycle after its request (registered array). A FIFO entry is visible the cycle after it drains.
- pending is combinational from FIFO entry valid bits plus their thread/dst. A bit clears once no remaining entry targets that register.
- Ordering hazard: a main-pipe write to a register whose pending bit is set is illegal. Upstream HZU prevents it; a simulation assertion flags it.
- FIFO pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: STAGE_WB_BYPASS_EN.
- Defined: regfile output is write-through. The word being written this cycle (main, direct-mul or drained entry) appears combinationally on the regfile port in the same cycle, so the decode stage reads it one cycle earlier.
- Undefined: the regfile port shows registered state only; one-cycle write-to-read latency.

Decomposition:
- Package `common`:
  - typedef `wb_entry_t` (threadid_t thread, regid_t dst, word_t data);
  - constant `WB_FIFO_DEPTH`;
  - existing word_t, regid_t, threadid_t and n_threads.
- Sub-module `wb_fifo`: synchronous FIFO of wb_entry_t with push, pop, full, empty, count and entry-array outputs, async active-low reset. The pending decode lives in stage_wb.

Test Plan:
- Reset: pulse rst=0 after writes → every regfile word 0, fifo_count 0, mul_stall 0, pending 0.
- Main write: wb_valid, thread 1, dst 5, data 0xDEADBEEF → regfile[1][5]=0xDEADBEEF next cycle; no other word changes.
- Register zero: wb (t2, r0, 0x1234) and mul (t3, r0, 0x5678) in separate cycles → regfile[*][0] stays 0, fifo_count stays 0.
- Collision:
  - same cycle wb (t0, r3, 0x11) and mul (t2, r7, 0x22) → next cycle r3=0x11, pending[2][7]=1, fifo_count=1;
  - following idle cycle → regfile[2][7]=0x22, pending 0.
- Backpressure: three consecutive cycles of wb+mul with distinct dst → mul_stall=1 after two enqueues and the third mul result is held; wb idle → entries drain in enqueue order, held result accepted after stall drops.
- Reset mid-drain: FIFO holding 2 entries, rst=0 → pending 0 and fifo_count 0 immediately, regfile cleared, no buffered write lands after release.

Source files
------------

// File: rtl/stage_wb_pkg.sv
// Shared pipeline types: thread/register/word widths and the buffered writeback entry.
package common;
  localparam int n_threads = 4;
  localparam int WB_FIFO_DEPTH = 2;

  typedef logic [31:0] word_t;
  typedef logic [4:0] regid_t;
  typedef logic [$clog2(n_threads)-1:0] threadid_t;

  typedef struct packed {
    threadid_t thread;
    regid_t    dst;
    word_t     data;
  } wb_entry_t;
endpackage

// File: rtl/stage_wb_fifo.sv
// In-order FIFO of multiplier writebacks; exposes every slot and its valid bit
// so the owner can decode pending registers. Push is ignored when full, pop when empty.
module wb_fifo
  import common::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t [DEPTH-1:0]    entries,
  output logic [DEPTH-1:0]         entry_vld
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries[i] = mem[i];
  end

  // Payload needs no reset: entry_vld qualifies every slot.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      entry_vld <= '0;
    end else begin
      if (do_push) begin
        entry_vld[wr_ptr] <= 1'b1;
        wr_ptr            <= PW'(wr_ptr + 1'b1);
      end
      if (do_pop) begin
        entry_vld[rd_ptr] <= 1'b0;
        rd_ptr            <= PW'(rd_ptr + 1'b1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/stage_wb.sv
// Writeback stage owning the per-thread register file; main pipe wins, colliding multiplier
// results queue in order. STAGE_WB_BYPASS_EN makes the regfile output write-through.
module stage_wb
  import common::*;
#(
  parameter int N_THREADS  = n_threads,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wb_valid,
  input  threadid_t                         wb_thread,
  input  regid_t                            wb_dst,
  input  word_t                             wb_data,
  input  logic                              mul_valid,
  input  threadid_t                         mul_thread,
  input  regid_t                            mul_dst,
  input  word_t                             mul_data,
  output logic                              mul_stall,
  output logic [N_THREADS-1:0][31:0]        pending,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output word_t [N_THREADS-1:0][31:0]       regfile
);
  word_t [N_THREADS-1:0][31:0] regs;

  wb_entry_t                   head;
  wb_entry_t [FIFO_DEPTH-1:0]  entries;
  logic [FIFO_DEPTH-1:0]       entry_vld;
  logic                        full;
  logic                        empty;
  logic                        mul_live;
  logic                        push;
  logic                        pop;
  logic                        direct;

  logic                        we;
  threadid_t                   wr_thread;
  regid_t                      wr_dst;
  word_t                       wr_data;

  assign mul_stall = full;
  // Writes to r0 are accepted from the multiplier but vanish here.
  assign mul_live  = mul_valid && !full && (mul_dst != '0);
  assign push      = mul_live && (wb_valid || !empty);
  assign pop       = !wb_valid && !empty;
  assign direct    = mul_live && !wb_valid && empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry ('{thread: mul_thread, dst: mul_dst, data: mul_data}),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (fifo_count),
    .entries    (entries),
    .entry_vld  (entry_vld)
  );

  always_comb begin
    we        = 1'b0;
    wr_thread = head.thread;
    wr_dst    = head.dst;
    wr_data   = head.data;
    if (wb_valid) begin
      we        = (wb_dst != '0);
      wr_thread = wb_thread;
      wr_dst    = wb_dst;
      wr_data   = wb_data;
    end else if (!empty) begin
      we = 1'b1;
    end else if (direct) begin
      we        = 1'b1;
      wr_thread = mul_thread;
      wr_dst    = mul_dst;
      wr_data   = mul_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else if (we) begin
      regs[wr_thread][wr_dst] <= wr_data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_vld[i]) pending[entries[i].thread][entries[i].dst] = 1'b1;
    end
  end

`ifdef STAGE_WB_BYPASS_EN
  always_comb begin
    regfile = regs;
    if (we) regfile[wr_thread][wr_dst] = wr_data;
  end
`else
  assign regfile = regs;
`endif

  // A main write overtaking a buffered write to the same register would reorder them.
  a_no_wb_hazard: assert property (@(posedge clk) disable iff (!rst)
    (wb_valid && wb_dst != '0) |-> !pending[wb_thread][wb_dst])
    else $error("stage_wb: main write to pending register t%0d r%0d", wb_thread, wb_dst);
endmodule
